maxpool_window_gen: RTL

MAXPOOL_WINDOW_GEN -- requirements
Module: maxpool_window_gen

---
 rtl/maxpool_window_gen_pkg.sv | 16 +
 rtl/line_buffer.sv | 25 ++
 rtl/maxpool_window_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/maxpool_window_gen_pkg.sv
// Shared pixel/window types for the window generator and the max-pool stage.
package maxpool_window_gen_pkg;

  localparam int PIX_W = 16;
  localparam int WIN_N = 9;

  typedef logic signed [PIX_W-1:0]            pix_t;
  typedef logic signed [WIN_N-1:0][PIX_W-1:0] win_t;

  // True when a row or column index lands on the window emission grid:
  // the window needs two earlier lines/columns, then repeats every stride.
  function automatic logic on_grid(input int unsigned pos, input int unsigned stride);
    return (pos >= 2) && ((stride == 1) || (pos[0] == 1'b0));
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage: combinational read, write on accepted pixel.
module line_buffer
  import maxpool_window_gen_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           addr,
  input  logic signed [PIX_W-1:0] wdata,
  output logic signed [PIX_W-1:0] rdata
);

  pix_t mem [DEPTH];

  // Read the previous line's pixel at this column before it is overwritten.
  assign rdata = mem[addr];

  // Storage is data only; it is never read before rows 0 and 1 rewrite it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
  end

endmodule

// File: rtl/maxpool_window_gen.sv
// Raster-scan 3x3 window generator feeding a 3x3 max-pool stage.
module maxpool_window_gen
  import maxpool_window_gen_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int STRIDE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [15:0]       in_data,
  input  logic                     in_valid,
  input  logic                     in_sof,
  output logic                     in_ready,
  output logic signed [8:0][15:0]  out_win,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_eff, col_nxt;
  logic [RW-1:0] row_q, row_eff, row_nxt;
  logic          accept, emit, last_col, last_row;
  pix_t          mid_rd, top_rd;
  win_t          win_q, win_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Position of the pixel being offered; start-of-frame overrides the counters.
  always_comb begin
    col_eff  = in_sof ? '0 : col_q;
    row_eff  = in_sof ? '0 : row_q;
    last_col = (col_eff == CW'(IMG_W - 1));
    last_row = (row_eff == RW'(IMG_H - 1));
    col_nxt  = last_col ? '0 : col_eff + 1'b1;
    row_nxt  = row_eff;
    if (last_col) row_nxt = last_row ? '0 : row_eff + 1'b1;
    emit     = on_grid(32'(col_eff), STRIDE) && on_grid(32'(row_eff), STRIDE);
  end

  // Line r-1 feeds the middle window row and is then pushed into line r-2.
  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb_mid (
    .clk   (clk),
    .wr_en (accept),
    .addr  (col_eff),
    .wdata (in_data),
    .rdata (mid_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb_top (
    .clk   (clk),
    .wr_en (accept),
    .addr  (col_eff),
    .wdata (mid_rd),
    .rdata (top_rd)
  );

  // Window after this pixel: each row shifts left, newest column enters on the right.
  always_comb begin
    win_nxt = win_q;
    for (int r = 0; r < 3; r++) begin
      win_nxt[3*r]     = win_q[3*r + 1];
      win_nxt[3*r + 1] = win_q[3*r + 2];
    end
    win_nxt[2] = top_rd;
    win_nxt[5] = mid_rd;
    win_nxt[8] = in_data;
  end

  // Shift-register window; emission only after two full columns of this row.
  always_ff @(posedge clk) begin
    if (accept) win_q <= win_nxt;
  end

  // Counters, output register and frame pulse; a new window may replace a
  // transferring one in the same cycle so throughput stays one per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      out_valid  <= 1'b0;
      out_win    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_col && last_row;
      if (accept) begin
        col_q <= col_nxt;
        row_q <= row_nxt;
      end
      if (accept && emit) begin
        out_valid <= 1'b1;
        out_win   <= win_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
